// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and framing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Receiver FSM state type; plain constants keep the encoding visible to older tools.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_PARITY    = 3'd3;
  localparam state_t ST_STOP      = 3'd4;
  localparam state_t ST_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/byte_fifo.sv
// Generic first-word-fall-through synchronous FIFO with power-of-two depth.
// Latency: a pushed word is visible at rd_data the cycle after the push edge (no bypass).
// Backpressure: writes while full are ignored unless a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head word is shown directly; zero when nothing is held.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update for accepted pushes and pops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with 16x oversampling feeding a byte FIFO.
// Latency: byte enters the FIFO one clock after the stop-bit sample tick; rd_valid follows the next cycle.
// Backpressure: rd_valid/rd_ready pop; a byte arriving while full with no pop is dropped and overrun pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int TICK_DIV   = 54,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  MID_LAST  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  logic        rx_meta;
  logic        rx_s;
  logic [15:0] tick_cnt;
  logic        tick;
  state_t      state;
  logic [3:0]  os;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        push_vld;
  logic        pop;
  logic        full;
  logic        empty;
  logic        start_edge;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad;
`endif

  // Two-flop synchronizer for the asynchronous pin; resets to the idle (high) level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign start_edge = (state == ST_IDLE) && !rx_s;
  assign tick       = (tick_cnt == TICK_LAST);

  // Oversample tick divider; restarted on the start edge so samples land mid-bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (start_edge || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Deframing FSM: start validation, LSB-first data capture, optional parity, stop check.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      os         <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      push_vld   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      parity_bad <= 1'b0;
`endif
    end else begin
      push_vld   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            os    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os == MID_LAST) begin
              if (!rx_s) begin
                state   <= ST_DATA;
                bit_idx <= '0;
                os      <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              os <= os + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            os <= os + 1'b1;
            if (os == OS_LAST) begin
              shift   <= {rx_s, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            os <= os + 1'b1;
            if (os == OS_LAST) begin
              parity_bad <= (rx_s != ^shift);
              parity_err <= (rx_s != ^shift);
              state      <= ST_STOP;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            os <= os + 1'b1;
            if (os == OS_LAST) begin
              if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                push_vld <= !parity_bad;
`else
                push_vld <= 1'b1;
`endif
                state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
              end
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop      = rd_valid && rd_ready;
  assign rd_valid = !empty;
  assign overrun  = push_vld && full && !pop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_vld),
    .push_data (shift),
    .pop       (pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard and pulse counters.
// Latency: frames are driven cycle by cycle at 64 clocks per bit (TICK_DIV=4).
// Backpressure: rd_ready is driven by the bench to pop bytes or to collide with a push.
module tb_uart_rx_fifo;

  logic       clk;
  logic       resetn;
  logic       uart_rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_base;
  int ov_base;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .TICK_DIV   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .uart_rx    (uart_rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count error pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #2ms;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 10-bit frame; rd_ready is raised for the single cycle after edge pop_cyc.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pop_cyc, input int ncyc);
    logic [9:0] fr;
    fr = {stop_b, d, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      uart_rx  = fr[i / 64];
      rd_ready = (i == pop_cyc);
    end
    rd_ready = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, -1, 640);
    exp_q.push_back(d);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Compare the head byte against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    @(negedge clk);
    check({tag, "_vld"}, 32'(rd_valid), 32'd1);
    check({tag, "_dat"}, 32'(rd_data), 32'(e));
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    uart_rx  = 1'b1;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_vld", 32'(rd_valid), 32'd0);
    check("rst_dat", 32'(rd_data), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Two bytes buffered, then popped one at a time.
    send_good(8'h55);
    send_good(8'hA3);
    @(negedge clk);
    check("two_cnt", 32'(fifo_count), 32'd2);
    pop_check("two_first");
    @(negedge clk);
    check("two_cnt_after", 32'(fifo_count), 32'd1);
    check("two_head", 32'(rd_data), 32'(exp_q[0]));
    pop_check("two_second");
    @(negedge clk);
    check("two_empty_cnt", 32'(fifo_count), 32'd0);
    check("two_empty_dat", 32'(rd_data), 32'd0);

    // Short low glitch on the idle line.
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (800) @(posedge clk);
    @(negedge clk);
    check("glitch_cnt", 32'(fifo_count), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe_base), 32'd0);
    check("glitch_ov", 32'(ov_cnt - ov_base), 32'd0);

    // Framing error followed by a break, then a clean byte.
    fe_base = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, 640);
    repeat (200) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("brk_fe", 32'(fe_cnt - fe_base), 32'd1);
    check("brk_cnt", 32'(fifo_count), 32'd0);
    send_good(8'h11);
    @(negedge clk);
    check("brk_next_cnt", 32'(fifo_count), 32'd1);
    pop_check("brk_next");

    // Nine bytes into an eight-entry FIFO: the ninth is dropped.
    ov_base = ov_cnt;
    for (int b = 0; b < 9; b++) begin
      send_frame(8'(b), 1'b1, -1, 640);
      if (b < 8) exp_q.push_back(8'(b));
      repeat (4) @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("ovf_cnt", 32'(fifo_count), 32'd8);
    check("ovf_pulses", 32'(ov_cnt - ov_base), 32'd1);
    for (int b = 0; b < 8; b++) pop_check($sformatf("ovf_pop%0d", b));
    @(negedge clk);
    check("ovf_drained", 32'(fifo_count), 32'd0);

    // Full FIFO with a pop in the same cycle as the ninth push.
    for (int b = 0; b < 8; b++) send_good(8'h80 + 8'(b));
    ov_base = ov_cnt;
    void'(exp_q.pop_front());
    send_frame(8'h88, 1'b1, 611, 640);
    exp_q.push_back(8'h88);
    @(negedge clk);
    check("coll_cnt", 32'(fifo_count), 32'd8);
    check("coll_ov", 32'(ov_cnt - ov_base), 32'd0);
    for (int b = 0; b < 8; b++) pop_check($sformatf("coll_pop%0d", b));

    // Reset in the middle of a frame discards everything.
    send_good(8'h77);
    fe_base = fe_cnt;
    send_frame(8'hFF, 1'b1, -1, 200);
    resetn  = 1'b0;
    uart_rx = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_vld", 32'(rd_valid), 32'd0);
    check("mid_rst_cnt", 32'(fifo_count), 32'd0);
    check("mid_rst_dat", 32'(rd_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (800) @(posedge clk);
    @(negedge clk);
    check("post_rst_cnt", 32'(fifo_count), 32'd0);
    check("post_rst_fe", 32'(fe_cnt - fe_base), 32'd0);
    send_good(8'h42);
    @(negedge clk);
    check("post_rst_one", 32'(fifo_count), 32'd1);
    pop_check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
